// File: rtl/i2c_reg_writer.sv
// I2C master issuing a single 3-byte register write (dev_addr, reg_addr, reg_value).
// Open-drain outputs: *_oe=1 pulls the line low; the pad tristate lives at the top level.
module i2c_reg_writer #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  dev_addr,
    input  logic [15:0] reg_data,
    output logic        ready,
    output logic        ack,
    output logic [7:0]  states,
    input  logic        sda_in,
    input  logic        scl_in,
    output logic        sda_oe,
    output logic        scl_oe
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_BIT   = 4'd2,
        S_ACK   = 4'd3,
        S_STOP  = 4'd4,
        S_DONE  = 4'd5
    } state_t;

    state_t        fsm_q;
    logic [1:0]    ph_q;
    logic [1:0]    byte_q;
    logic [2:0]    bit_q;
    logic [23:0]   sh_q;
    logic          nack_q;
    logic          ready_q;
    logic          ack_q;
    logic          sda_oe_q;
    logic          scl_oe_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic run;
    logic stretch;
    logic tick;

    assign run     = fsm_q inside {S_START, S_BIT, S_ACK, S_STOP};
    // Slave holding SCL low while we have released it.
    assign stretch = !scl_oe_q && !scl_in;
    assign tick    = run && !stretch && (cnt_q == CMAX);

    always_comb begin
        cnt_d = cnt_q;
        if (!run)
            cnt_d = '0;
        else if (!stretch)
            cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            fsm_q    <= S_IDLE;
            ph_q     <= 2'd0;
            byte_q   <= 2'd0;
            bit_q    <= 3'd0;
            sh_q     <= 24'd0;
            nack_q   <= 1'b0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            sda_oe_q <= 1'b0;
            scl_oe_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    sda_oe_q <= 1'b0;
                    scl_oe_q <= 1'b0;
                    if (start && ready_q) begin
                        fsm_q    <= S_START;
                        ph_q     <= 2'd0;
                        byte_q   <= 2'd0;
                        bit_q    <= 3'd7;
                        sh_q     <= {dev_addr & 8'hFE, reg_data};
                        nack_q   <= 1'b0;
                        ack_q    <= 1'b0;
                        ready_q  <= 1'b0;
                        sda_oe_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (ph_q == 2'd0) begin
                            ph_q     <= 2'd1;
                            scl_oe_q <= 1'b1;
                        end else begin
                            fsm_q    <= S_BIT;
                            ph_q     <= 2'd0;
                            sda_oe_q <= ~sh_q[23];
                        end
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        ph_q <= ph_q + 2'd1;
                        unique case (ph_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd1: ;
                            2'd2: scl_oe_q <= 1'b1;
                            2'd3: begin
                                sh_q <= sh_q << 1;
                                if (bit_q == 3'd0) begin
                                    fsm_q    <= S_ACK;
                                    sda_oe_q <= 1'b0;
                                end else begin
                                    bit_q    <= bit_q - 3'd1;
                                    sda_oe_q <= ~sh_q[22];
                                end
                            end
                        endcase
                    end
                end
                S_ACK: begin
                    if (tick) begin
                        ph_q <= ph_q + 2'd1;
                        unique case (ph_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd1: ;
                            2'd2: begin
                                scl_oe_q <= 1'b1;
                                if (sda_in)
                                    nack_q <= 1'b1;
                            end
                            2'd3: begin
                                if (nack_q || byte_q == 2'd2) begin
                                    fsm_q    <= S_STOP;
                                    sda_oe_q <= 1'b1;
                                end else begin
                                    fsm_q    <= S_BIT;
                                    byte_q   <= byte_q + 2'd1;
                                    bit_q    <= 3'd7;
                                    sda_oe_q <= ~sh_q[23];
                                end
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        ph_q <= ph_q + 2'd1;
                        unique case (ph_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd1: sda_oe_q <= 1'b0;
                            2'd2: ;
                            2'd3: fsm_q <= S_DONE;
                        endcase
                    end
                end
                S_DONE: begin
                    fsm_q   <= S_IDLE;
                    ph_q    <= 2'd0;
                    ready_q <= 1'b1;
                    ack_q   <= ~nack_q;
                end
                default: begin
                    fsm_q    <= S_STOP;
                    ph_q     <= 2'd0;
                    scl_oe_q <= 1'b1;
                    sda_oe_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign ack    = ack_q;
    assign sda_oe = sda_oe_q;
    assign scl_oe = scl_oe_q;
    assign states = {fsm_q, byte_q, ph_q};

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Bench for i2c_reg_writer: bus-level I2C slave/monitor decoding the open-drain lines.
// Expected bytes, ACK result and latencies come from the transfer rules, not the RTL.
module tb_i2c_reg_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  dev;
    logic [15:0] data;
    logic        ready, ack, sda_oe, scl_oe;
    logic [7:0]  states;
    logic        slave_pull = 1'b0;
    logic        stretch = 1'b0;
    logic        sda, scl;

    assign sda = !(sda_oe || slave_pull);
    assign scl = !(scl_oe || stretch);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_reg_writer #(.CLK_DIV(4)) dut (
        .clk_in(clk), .reset(rst), .start(start),
        .dev_addr(dev), .reg_data(data),
        .ready(ready), .ack(ack), .states(states),
        .sda_in(sda), .scl_in(scl),
        .sda_oe(sda_oe), .scl_oe(scl_oe)
    );

    // Slave / monitor state
    logic [7:0] rx[$];
    int   n_start = 0, n_stop = 0;
    logic scl_p = 1'b1, sda_p = 1'b1, oe_p = 1'b0;
    int   bitc = 0, nbytes = 0, pulls = 0, left = 0;
    logic [7:0] shr = 8'd0;
    int   nack_at = 3;
    bit   stretch_arm = 1'b0;

    always @(negedge clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda;
        if (stretch && !scl_oe) begin
            if (left == 0) stretch = 1'b0;
            else left--;
        end
        if (scl_p && s_scl && sda_p && !s_sda) begin
            n_start++;
            bitc = 0; nbytes = 0; pulls = 0; slave_pull = 1'b0;
        end else if (scl_p && s_scl && !sda_p && s_sda) begin
            n_stop++;
        end else if (!scl_p && s_scl) begin
            if (bitc < 8) begin
                shr = {shr[6:0], s_sda};
                bitc++;
                if (bitc == 8) begin
                    rx.push_back(shr);
                    nbytes++;
                end
            end else begin
                bitc = 0;
            end
        end else if (scl_p && !s_scl) begin
            slave_pull = (bitc == 8) && ((nbytes - 1) != nack_at);
        end
        if (scl_oe && !oe_p) begin
            pulls++;
            // 14th SCL release after START is byte 1, bit 3
            if (stretch_arm && pulls == 14) begin
                stretch = 1'b1;
                left = 20;
            end
        end
        scl_p = s_scl;
        sda_p = s_sda;
        oe_p  = scl_oe;
    end

    int n_err = 0, n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] d, input logic [15:0] r, output int n);
        @(negedge clk);
        dev = d; data = r; start = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        chk("accept_busy", ready, 1'b0);
        chk("accept_ack_clr", ack, 1'b0);
    endtask

    task automatic wait_ready(input int n, input int exp_lat, input string tag);
        while (ready !== 1'b1 && (cyc - n) < 3000) begin
            @(posedge clk); #1;
        end
        chk(tag, cyc - n, exp_lat);
    endtask

    task automatic check_bytes(input int base, input logic [7:0] e[6], input int nb,
                               input string tag);
        chk({tag, "_nbytes"}, rx.size() - base, nb);
        for (int i = 0; i < nb; i++)
            if (base + i < rx.size())
                chk({tag, "_byte"}, rx[base + i], e[i]);
    endtask

    task automatic xfer(input logic [7:0] d, input logic [15:0] r, input int nk,
                        input bit arm, input bit meddle, input string tag);
        logic [7:0] e[6];
        int nb, ticks, n, base, s0, p0;
        e[0] = d & 8'hFE; e[1] = r[15:8]; e[2] = r[7:0];
        e[3] = 8'd0; e[4] = 8'd0; e[5] = 8'd0;
        nb    = (nk < 3) ? nk + 1 : 3;
        ticks = 2 + 36 * nb + 4;
        base = rx.size(); s0 = n_start; p0 = n_stop;
        nack_at = nk; stretch_arm = arm;
        launch(d, r, n);
        start = 1'b0;
        if (meddle) begin
            repeat (3) begin
                repeat (60) @(negedge clk);
                dev = 8'($urandom); data = 16'($urandom); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_ready(n, ticks * 4 + 1 + (arm ? 20 : 0), {tag, "_latency"});
        chk({tag, "_ack"}, ack, (nk >= 3));
        check_bytes(base, e, nb, tag);
        chk({tag, "_starts"}, n_start - s0, 1);
        chk({tag, "_stops"}, n_stop - p0, 1);
        chk({tag, "_released"}, {sda_oe, scl_oe}, 2'b00);
        stretch_arm = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, base, s0, p0;
        logic [7:0] e6[6];
        rst = 1'b1; start = 1'b0; dev = 8'd0; data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_ack", ack, 1'b0);
        chk("rst_lines", {sda_oe, scl_oe}, 2'b00);
        chk("rst_states", states, 8'h00);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_lines", {sda_oe, scl_oe}, 2'b00);

        xfer(8'h72, 16'h9803, 3, 1'b0, 1'b0, "write_ack");
        xfer(8'h72, 16'h9803, 0, 1'b0, 1'b0, "nack_addr");
        xfer(8'h72, 16'h9803, 1, 1'b0, 1'b0, "nack_reg");
        xfer(8'h72, 16'h5AC3, 3, 1'b1, 1'b0, "stretch");
        xfer(8'h72, 16'h3C81, 3, 1'b0, 1'b1, "busy_ignore");

        // Reset in the middle of a transfer
        launch(8'h72, 16'h1234, n);
        start = 1'b0;
        repeat (198) @(posedge clk);
        #1;
        chk("pre_reset_busy", ready, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_lines", {sda_oe, scl_oe}, 2'b00);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_ack", ack, 1'b0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        xfer(8'h72, 16'hAF16, 3, 1'b0, 1'b0, "after_reset");

        // Back-to-back with start held high, bit0 of address forced low
        base = rx.size(); s0 = n_start; p0 = n_stop;
        nack_at = 3;
        launch(8'h73, 16'hC0DE, n);
        wait_ready(n, 457, "b2b_first_latency");
        chk("b2b_first_ack", ack, 1'b1);
        @(posedge clk); #1;
        chk("b2b_second_busy", ready, 1'b0);
        chk("b2b_second_fsm", states[7:4], 4'd1);
        n = cyc;
        start = 1'b0;
        wait_ready(n, 457, "b2b_second_latency");
        chk("b2b_second_ack", ack, 1'b1);
        e6[0] = 8'h72; e6[1] = 8'hC0; e6[2] = 8'hDE;
        e6[3] = 8'h72; e6[4] = 8'hC0; e6[5] = 8'hDE;
        check_bytes(base, e6, 6, "b2b");
        chk("b2b_starts", n_start - s0, 2);
        chk("b2b_stops", n_stop - p0, 2);

        // Randomised requests and ACK patterns
        for (int k = 0; k < 4; k++)
            xfer(8'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                 1'b0, 1'b0, "random");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
